// File: rtl/sprite_renderer.sv
// Pipelined sprite engine: maps the scan position onto a scaled, animated sprite, drives the ROM address and emits a hit-flagged palette index.
// Optional feature: define SPRITE_MIRROR_EN to add the horizontal-flip 'mirror' input.
module sprite_renderer #(
  parameter int SPR_W           = 60,
  parameter int SPR_H           = 60,
  parameter int NUM_FRAMES      = 2,
  parameter int ADDR_W          = 13,
  parameter int ROM_LAT         = 1,
  parameter int FRAME_TICKS     = 4,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale,
  input  logic              anim_en,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror,
`endif
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [7:0]        pix_idx,
  output logic              pix_hit,
  output logic              pix_active
);

  localparam int FRAME_SIZE = SPR_W * SPR_H;
  localparam int FRAME_W    = (NUM_FRAMES  > 1) ? $clog2(NUM_FRAMES)  : 1;
  localparam int TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  // Shadow copies of the placement controls, only updated during vertical blank.
  logic [9:0]         px_s;
  logic [9:0]         py_s;
  logic [1:0]         scale_s;
  logic [FRAME_W-1:0] frame;
  logic [TICK_W-1:0]  tick;
`ifdef SPRITE_MIRROR_EN
  logic               mirror_s;
`endif

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px_s    <= '0;
      py_s    <= '0;
      scale_s <= '0;
`ifdef SPRITE_MIRROR_EN
      mirror_s <= 1'b0;
`endif
    end else if (frame_start) begin
      px_s    <= pos_x;
      py_s    <= pos_y;
      scale_s <= scale;
`ifdef SPRITE_MIRROR_EN
      mirror_s <= mirror;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick  <= '0;
      frame <= '0;
    end else if (frame_start && anim_en) begin
      if (tick == TICK_W'(FRAME_TICKS - 1)) begin
        tick  <= '0;
        frame <= (frame == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame + FRAME_W'(1);
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

  // Stage 0: texel coordinates from the current scan position.
  logic [10:0]       dx, dy, u, v, u_m;
  logic              in_box;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] addr_next;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, px_s};
    dy     = {1'b0, DrawY} - {1'b0, py_s};
    u      = dx >> scale_s;
    v      = dy >> scale_s;
    // The >= tests reject negative offsets, so the sprite clips instead of wrapping.
    in_box = (DrawX >= px_s) && (DrawY >= py_s) &&
             (u < 11'(SPR_W)) && (v < 11'(SPR_H));
`ifdef SPRITE_MIRROR_EN
    u_m    = mirror_s ? (11'(SPR_W - 1) - u) : u;
`else
    u_m    = u;
`endif
    frame_base = ADDR_W'(frame) * ADDR_W'(FRAME_SIZE);
    addr_next  = '0;
    if (in_box)
      addr_next = frame_base + ADDR_W'(v) * ADDR_W'(SPR_W) + ADDR_W'(u_m);
  end

  // Stage 1: ROM address plus in_box/blank delay line spanning the ROM latency.
  logic [ROM_LAT:0] in_box_d;
  logic [ROM_LAT:0] blank_d;

  // NOTE: the short delay line is reset with the rest of the pipeline so a mid-frame
  // reset cannot leak stale hits; this is flops, not a memory array.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      in_box_d    <= '0;
      blank_d     <= '0;
    end else begin
      rom_address <= addr_next;
      if (ROM_LAT > 0) begin
        in_box_d <= {in_box_d[ROM_LAT-1:0], in_box};
        blank_d  <= {blank_d[ROM_LAT-1:0],  blank};
      end else begin
        in_box_d <= in_box;
        blank_d  <= blank;
      end
    end
  end

  // Final stage: register ROM data with its matching qualifiers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_idx    <= '0;
      pix_hit    <= 1'b0;
      pix_active <= 1'b0;
    end else begin
      pix_idx    <= rom_q;
      pix_hit    <= in_box_d[ROM_LAT] & blank_d[ROM_LAT] & (rom_q != 8'(TRANSPARENT_IDX));
      pix_active <= blank_d[ROM_LAT];
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer (default parameters, ROM_LAT=1); mirror checks run when SPRITE_MIRROR_EN is defined.
module tb_sprite_renderer;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        blank, frame_start, anim_en;
  logic [1:0]  scale;
  logic [12:0] rom_address;
  logic [7:0]  rom_q;
  logic [7:0]  pix_idx;
  logic        pix_hit, pix_active;
`ifdef SPRITE_MIRROR_EN
  logic        mirror;
`endif

  logic        rom_force_en;
  logic [7:0]  rom_force;
  int          n_asserts = 0;
  int          n_fail    = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_renderer dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .scale       (scale),
    .anim_en     (anim_en),
`ifdef SPRITE_MIRROR_EN
    .mirror      (mirror),
`endif
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_idx     (pix_idx),
    .pix_hit     (pix_hit),
    .pix_active  (pix_active)
  );

  // One-cycle ROM model: data is address+1 unless forced to a chosen value.
  always @(posedge vga_clk)
    rom_q <= rom_force_en ? rom_force : rom_address[7:0] + 8'd1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic [12:0] exp_addr,
                          input logic exp_hit, input logic exp_active);
    logic [7:0] exp_idx;
    exp_idx = rom_force_en ? rom_force : exp_addr[7:0] + 8'd1;
    check({tag, "_addr"},   16'(rom_address), 16'(exp_addr));
    check({tag, "_hit"},    16'(pix_hit),     16'(exp_hit));
    check({tag, "_idx"},    16'(pix_idx),     16'(exp_idx));
    check({tag, "_active"}, 16'(pix_active),  16'(exp_active));
  endtask

  // Hold a scan position for the full pipeline latency, then sample.
  task automatic apply(input logic [9:0] x, input logic [9:0] y);
    DrawX = x;
    DrawY = y;
    repeat (3) @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(posedge vga_clk);
      #1;
      frame_start = 1'b0;
      @(posedge vga_clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0; anim_en = 1'b0;
    rom_force_en = 1'b0; rom_force = 8'h00;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    #1;
    check("reset_addr",   16'(rom_address), 16'd0);
    check("reset_hit",    16'(pix_hit),     16'd0);
    check("reset_active", 16'(pix_active),  16'd0);
    repeat (3) @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    blank   = 1'b1;
    pulse(1);

    // Basic 1x mapping and right/bottom edges
    apply(10'd159, 10'd50);  check_px("t2_x159", 13'd59, 1'b1, 1'b1);
    DrawX = 10'd100;
    @(posedge vga_clk); #1;
    check("t2_addr_next_cycle", 16'(rom_address), 16'd0);
    repeat (2) @(posedge vga_clk); #1;
    check_px("t2_x100", 13'd0, 1'b1, 1'b1);
    apply(10'd160, 10'd50);  check_px("t2_x160", 13'd0, 1'b0, 1'b1);
    apply(10'd100, 10'd109); check_px("t2_y109", 13'd3540, 1'b1, 1'b1);
    apply(10'd100, 10'd110); check_px("t2_y110", 13'd0, 1'b0, 1'b1);
    apply(10'd99,  10'd50);  check_px("t2_x99",  13'd0, 1'b0, 1'b1);
    apply(10'd100, 10'd49);  check_px("t2_y49",  13'd0, 1'b0, 1'b1);

    // 2x and 8x scaling
    scale = 2'd1; pulse(1);
    apply(10'd102, 10'd53);  check_px("t3_s1_61",   13'd61, 1'b1, 1'b1);
    apply(10'd219, 10'd50);  check_px("t3_s1_x219", 13'd59, 1'b1, 1'b1);
    apply(10'd220, 10'd50);  check_px("t3_s1_x220", 13'd0,  1'b0, 1'b1);
    apply(10'd99,  10'd50);  check_px("t3_s1_x99",  13'd0,  1'b0, 1'b1);
    apply(10'd100, 10'd169); check_px("t3_s1_y169", 13'd3540, 1'b1, 1'b1);
    apply(10'd100, 10'd170); check_px("t3_s1_y170", 13'd0,  1'b0, 1'b1);
    scale = 2'd3; pulse(1);
    apply(10'd579, 10'd50);  check_px("t3_s3_x579", 13'd59, 1'b1, 1'b1);
    apply(10'd580, 10'd50);  check_px("t3_s3_x580", 13'd0,  1'b0, 1'b1);
    scale = 2'd0; pulse(1);

    // Colour-key transparency and blanking
    rom_force_en = 1'b1; rom_force = 8'h00;
    apply(10'd110, 10'd60);  check_px("t4_transparent", 13'd610, 1'b0, 1'b1);
    rom_force = 8'h2A;
    apply(10'd110, 10'd60);  check_px("t4_opaque",      13'd610, 1'b1, 1'b1);
    blank = 1'b0;
    apply(10'd110, 10'd60);  check_px("t4_blank",       13'd610, 1'b0, 1'b0);
    blank = 1'b1; rom_force_en = 1'b0;

    // Mid-frame position change must wait for frame_start
    pos_x = 10'd300;
    apply(10'd100, 10'd50);  check_px("t5_old_x100", 13'd0, 1'b1, 1'b1);
    apply(10'd300, 10'd50);  check_px("t5_old_x300", 13'd0, 1'b0, 1'b1);
    pulse(1);
    apply(10'd300, 10'd50);  check_px("t5_new_x300", 13'd0,  1'b1, 1'b1);
    apply(10'd359, 10'd50);  check_px("t5_new_x359", 13'd59, 1'b1, 1'b1);
    apply(10'd100, 10'd50);  check_px("t5_new_x100", 13'd0,  1'b0, 1'b1);
    pos_x = 10'd100; pulse(1);

    // Animation stepping, wrap and hold
    anim_en = 1'b1;
    pulse(3);
    apply(10'd100, 10'd50);  check_px("t6_p3",  13'd0,    1'b1, 1'b1);
    pulse(1);
    apply(10'd100, 10'd50);  check_px("t6_p4",  13'd3600, 1'b1, 1'b1);
    apply(10'd159, 10'd109); check_px("t6_p4_last", 13'd7199, 1'b1, 1'b1);
    pulse(4);
    apply(10'd100, 10'd50);  check_px("t6_p8",  13'd0,    1'b1, 1'b1);
    pulse(4);
    apply(10'd100, 10'd50);  check_px("t6_p12", 13'd3600, 1'b1, 1'b1);
    anim_en = 1'b0;
    pulse(4);
    apply(10'd100, 10'd50);  check_px("t6_hold", 13'd3600, 1'b1, 1'b1);

    // Reset mid-stream clears outputs at once and restores shadows/counters
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_addr",   16'(rom_address), 16'd0);
    check("t1_hit",    16'(pix_hit),     16'd0);
    check("t1_idx",    16'(pix_idx),     16'd0);
    check("t1_active", 16'(pix_active),  16'd0);
    repeat (2) @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
    apply(10'd0,   10'd0);   check_px("t1_origin",  13'd0,  1'b1, 1'b1);
    apply(10'd59,  10'd0);   check_px("t1_x59",     13'd59, 1'b1, 1'b1);
    apply(10'd100, 10'd50);  check_px("t1_oldpos",  13'd0,  1'b0, 1'b1);
    anim_en = 1'b1;
    pulse(3);
    apply(10'd100, 10'd50);  check_px("t1_tick3",   13'd0,    1'b1, 1'b1);
    pulse(1);
    apply(10'd100, 10'd50);  check_px("t1_tick4",   13'd3600, 1'b1, 1'b1);
    anim_en = 1'b0;

`ifdef SPRITE_MIRROR_EN
    mirror = 1'b1; pulse(1);
    apply(10'd100, 10'd50);  check_px("t7_mirror_l", 13'd3659, 1'b1, 1'b1);
    apply(10'd159, 10'd50);  check_px("t7_mirror_r", 13'd3600, 1'b1, 1'b1);
    mirror = 1'b0; pulse(1);
    apply(10'd100, 10'd50);  check_px("t7_unmirror", 13'd3600, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
